// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state encoding and credit counter width for pipe_arb_ctrl
package pipe_ctrl_pkg;
    localparam int CRD_W = 4;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter
//   clk, rst (sync, active-low) | vld[1:0] requests (bit0 = A) | upd: pointer update strobe | gnt[1:0] one-hot grant
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] vld,
    input  logic       upd,
    output logic [1:0] gnt
);
    logic ptr_q, ptr_d;
    // ptr_q=0 prefers A; after a grant the other requester gets preference
    always_comb begin
        gnt   = (vld == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : vld;
        ptr_d = (upd && gnt[0]) ? 1'b1 : (upd && gnt[1]) ? 1'b0 : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) ptr_q <= 1'b0;
        else      ptr_q <= ptr_d;
    end
endmodule

// File: rtl/pipe_arb_ctrl.sv
// pipe_arb_ctrl: credit-based two-requester arbiter driving an en-gated pipeline
//   clk, rst (sync, active-low)
//   en: run enable | req_x_vld/req_x_data/req_x_rdy: requester A/B handshake | crd_ret: downstream credit return
//   pipe_en/pipe_vld/pipe_type_x/pipe_data_x: stage controls and payloads
//   busy: FSM not idle | err: sticky credit overflow | crd_cnt: available credits
module pipe_arb_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DW      = 8,
    parameter int DEPTH   = 3,
    parameter int CREDITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             req_a_vld,
    input  logic             req_b_vld,
    input  logic             crd_ret,
    input  logic [DW-1:0]    req_a_data,
    input  logic [DW-1:0]    req_b_data,
    output logic             req_a_rdy,
    output logic             req_b_rdy,
    output logic             pipe_en,
    output logic             pipe_vld,
    output logic             pipe_type_a,
    output logic             pipe_type_b,
    output logic [DW-1:0]    pipe_data_a,
    output logic [DW-1:0]    pipe_data_b,
    output logic             busy,
    output logic             err,
    output logic [CRD_W-1:0] crd_cnt
);
    state_e            state_q, state_d;
    logic [CRD_W-1:0]  crd_q, crd_d;
    logic [DEPTH-1:0]  occ_q, occ_d;
    logic              err_q, err_d;
    logic [1:0]        gnt;
    logic              can_issue, issue, occ_any, full;
    // rst gating keeps every strobe low in the reset cycle itself
    assign can_issue = rst && (state_q == RUN) && (crd_q != '0);
    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .vld ({req_b_vld, req_a_vld} & {2{can_issue}}),
        .upd (can_issue),
        .gnt (gnt)
    );
    always_comb begin
        issue   = gnt[0] | gnt[1];
        occ_any = |occ_q;
        full    = (crd_q == CRD_W'(CREDITS));
        case (state_q)
            IDLE:    state_d = en ? RUN : IDLE;
            RUN:     state_d = en ? RUN : DRAIN;
            DRAIN:   state_d = en ? RUN : (occ_any ? DRAIN : IDLE);
            default: state_d = IDLE;
        endcase
        // a return against a full counter is an overflow: flag it, keep the count
        crd_d = (issue && !crd_ret)          ? crd_q - CRD_W'(1) :
                (crd_ret && !issue && !full) ? crd_q + CRD_W'(1) : crd_q;
        err_d = err_q | (crd_ret && !issue && full);
        occ_d = (occ_q << 1) | DEPTH'(issue);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            crd_q   <= CRD_W'(CREDITS);
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crd_q   <= crd_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
        end
    end
    assign req_a_rdy   = gnt[0];
    assign req_b_rdy   = gnt[1];
    assign pipe_vld    = issue;
    assign pipe_type_a = gnt[0];
    assign pipe_type_b = gnt[1];
    assign pipe_data_a = req_a_data;
    assign pipe_data_b = req_b_data;
    assign pipe_en     = rst && (issue || occ_any);
    assign busy        = rst && (state_q != IDLE);
    assign err         = err_q;
    assign crd_cnt     = crd_q;
endmodule
